mem_access_unit: RTL and testbench

Sequential load/store controller sitting directly downstream of the control sub-decoder: it consumes `MemRW`, `DataWSel` and `DataRSel` together with the ALU address and the rs2 store data. It runs one request/acknowledge transaction per memory instruction on a 32-bit data bus. It stalls the core while the transaction is outstanding and returns size-adjusted, sign/zero-extended load data to the write-back mux. Misaligned accesses and bus timeouts are reported as a one-cycle fault.

---
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Word-wide request/acknowledge memory bus between the load/store unit and memory.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// Sequential load/store controller: one bus transaction per memory instruction,
// stalls the core while outstanding, returns extended load data, flags faults.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        MemRW,
  input  logic [1:0]  DataWSel,
  input  logic [2:0]  DataRSel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  err_code,
  mem_access_unit_if.master bus
);

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  typedef struct packed {
    logic       we;
    logic [2:0] rsel;
    logic [1:0] lo;
  } req_t;

  state_t  state;
  req_t    req_q;
  logic [TW-1:0] tcnt;

  size_t   req_size;
  logic    misaligned;
  logic [NUM_LANES-1:0]            lane_be;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_wd;
  logic [31:0] shifted;
  logic [31:0] ld_ext;

  // Access size comes from the store selector for stores, the load selector for loads.
  always_comb begin
    req_size = SZ_WORD;
    if (MemRW) begin
      unique case (DataWSel)
        2'b01:   req_size = SZ_BYTE;
        2'b11:   req_size = SZ_HALF;
        default: req_size = SZ_WORD;
      endcase
    end else begin
      unique case (DataRSel)
        3'b001, 3'b011: req_size = SZ_BYTE;
        3'b010, 3'b100: req_size = SZ_HALF;
        default:        req_size = SZ_WORD;
      endcase
    end
  end

  assign misaligned = ((req_size == SZ_HALF) && addr[0]) ||
                      ((req_size == SZ_WORD) && (addr[1:0] != 2'b00));

  // Each lane picks its enable and the store byte that replicates onto it.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LI = 2'(i);
    assign lane_be[i] = (req_size == SZ_BYTE) ? (addr[1:0] == LI) :
                        (req_size == SZ_HALF) ? (addr[1] == LI[1]) : 1'b1;
    assign lane_wd[i] = (req_size == SZ_BYTE) ? wdata[7:0] :
                        (req_size == SZ_HALF) ? wdata[VEC_W*(i%2) +: VEC_W] :
                                                wdata[VEC_W*i +: VEC_W];
  end

  assign shifted = bus.bus_rdata >> {req_q.lo, 3'b000};

  always_comb begin
    ld_ext = shifted;
    unique case (req_q.rsel)
      3'b001:  ld_ext = {{24{shifted[7]}},  shifted[7:0]};
      3'b010:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b011:  ld_ext = {24'b0, shifted[7:0]};
      3'b100:  ld_ext = {16'b0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  // DONE/ERR must not stall so the instruction retires or traps that cycle.
  assign stall = ((state == IDLE) && mem_en) || (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_q         <= '0;
      tcnt          <= '0;
      rdata         <= '0;
      fault         <= 1'b0;
      err_code      <= 2'b00;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_en) begin
            if (misaligned) begin
              state    <= ERR;
              fault    <= 1'b1;
              err_code <= 2'b01;
            end else begin
              state         <= BUSY;
              tcnt          <= '0;
              req_q         <= '{we: MemRW, rsel: DataRSel, lo: addr[1:0]};
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= MemRW;
              bus.bus_addr  <= {addr[31:2], 2'b00};
              bus.bus_be    <= lane_be;
              bus.bus_wdata <= lane_wd;
            end
          end
        end
        BUSY: begin
          // Ack is checked first so an ack on the last allowed cycle still completes.
          if (bus.bus_ack) begin
            state       <= DONE;
            bus.bus_req <= 1'b0;
            if (!req_q.we) rdata <= ld_ext;
          end else if ((TIMEOUT != 0) && (tcnt == TLAST)) begin
            state       <= ERR;
            bus.bus_req <= 1'b0;
            fault       <= 1'b1;
            err_code    <= 2'b10;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        ERR: begin
          state    <= IDLE;
          fault    <= 1'b0;
          err_code <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: directed vector table, hand sequences and random traffic vs a size/lane model.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_en = 1'b0;
  logic        MemRW = 1'b0;
  logic [1:0]  DataWSel = 2'b00;
  logic [2:0]  DataRSel = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        fault;
  logic [1:0]  err_code;

  mem_access_unit_if bif();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .MemRW(MemRW),
    .DataWSel(DataWSel), .DataRSel(DataRSel), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .fault(fault), .err_code(err_code),
    .bus(bif.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] cur_rd = '0;

  typedef struct {
    bit        rw;
    bit [1:0]  ws;
    bit [2:0]  rs;
    bit [31:0] a;
    bit [31:0] wd;
    bit [31:0] rd;
    int        waits;
    bit [3:0]  be;
    bit [31:0] bw;
    bit [31:0] erd;
    bit [1:0]  err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: access size in bytes, then lanes/data from plain arithmetic.
  function automatic void model(input bit rw, input bit [1:0] ws, input bit [2:0] rs,
                                input bit [31:0] a, input bit [31:0] wd, input bit [31:0] rd,
                                output bit [3:0] be, output bit [31:0] bw,
                                output bit [31:0] ld, output bit mis);
    int sz;
    int off;
    bit [3:0] one;
    bit [3:0] two;
    one = 4'b0001;
    two = 4'b0011;
    off = int'(a % 4);
    if (rw) sz = (ws == 2'b01) ? 1 : (ws == 2'b11) ? 2 : 4;
    else    sz = (rs == 3'd1 || rs == 3'd3) ? 1 : (rs == 3'd2 || rs == 3'd4) ? 2 : 4;
    mis = (sz == 2 && (a % 2) != 0) || (sz == 4 && off != 0);
    be  = (sz == 1) ? (one << off) : (sz == 2) ? (two << (2 * (off / 2))) : 4'hF;
    bw  = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
    ld  = rd >> (8 * off);
    if (sz == 1) begin
      ld = ld & 32'hFF;
      if (rs == 3'd1 && ld >= 32'h80) ld = ld + 32'hFFFF_FF00;
    end else if (sz == 2) begin
      ld = ld & 32'hFFFF;
      if (rs == 3'd2 && ld >= 32'h8000) ld = ld + 32'hFFFF_0000;
    end
  endfunction

  // Starts at the IDLE cycle (cycle 0); returns at the negedge inside DONE/ERR.
  task automatic run_txn(input string tag, input bit rw, input bit [1:0] ws, input bit [2:0] rs,
                         input bit [31:0] a, input bit [31:0] wd, input bit [31:0] rd,
                         input int waits, input bit [3:0] ebe, input bit [31:0] ebw,
                         input bit [31:0] erd, input bit [1:0] eerr);
    int nb;
    @(negedge clk);
    mem_en = 1'b1; MemRW = rw; DataWSel = ws; DataRSel = rs; addr = a; wdata = wd;
    bif.bus_ack = 1'b0; bif.bus_rdata = $urandom;
    #1;
    chk({tag, ".c0_stall"}, stall, 1);
    chk({tag, ".c0_req"}, bif.bus_req, 0);
    chk({tag, ".c0_fault"}, fault, 0);
    @(negedge clk);
    mem_en = 1'b0;
    if (eerr == 2'd1) begin
      chk({tag, ".mis_fault"}, fault, 1);
      chk({tag, ".mis_code"}, err_code, 2'd1);
      chk({tag, ".mis_req"}, bif.bus_req, 0);
      chk({tag, ".mis_stall"}, stall, 0);
      chk({tag, ".mis_rdata"}, rdata, erd);
    end else begin
      nb = (waits < TO) ? waits + 1 : TO;
      for (int k = 0; k < nb; k++) begin
        chk({tag, ".busy_req"}, bif.bus_req, 1);
        chk({tag, ".busy_stall"}, stall, 1);
        chk({tag, ".busy_addr"}, bif.bus_addr, {a[31:2], 2'b00});
        chk({tag, ".busy_be"}, bif.bus_be, ebe);
        chk({tag, ".busy_we"}, bif.bus_we, rw);
        if (rw) chk({tag, ".busy_wdata"}, bif.bus_wdata, ebw);
        bif.bus_ack   = (k == waits);
        bif.bus_rdata = (k == waits) ? rd : $urandom;
        @(negedge clk);
      end
      bif.bus_ack = 1'b0;
      chk({tag, ".end_req"}, bif.bus_req, 0);
      chk({tag, ".end_stall"}, stall, 0);
      chk({tag, ".end_rdata"}, rdata, erd);
      chk({tag, ".end_fault"}, fault, (eerr == 2'd2));
      if (eerr == 2'd2) chk({tag, ".to_code"}, err_code, 2'd2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [3:0]  mbe;
    bit [31:0] mbw, mld, erd;
    bit        mis;
    bit [1:0]  eerr;
    bit        rw;
    bit [1:0]  ws;
    bit [2:0]  rs;
    bit [31:0] a, wd, rd;
    int        w;

    bif.bus_ack = 1'b0; bif.bus_rdata = '0;
    #12;
    chk("rst_req", bif.bus_req, 0);
    chk("rst_we", bif.bus_we, 0);
    chk("rst_be", bif.bus_be, 0);
    chk("rst_addr", bif.bus_addr, 0);
    chk("rst_wdata", bif.bus_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", err_code, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk); rst_n = 1'b1;

    tbl[0] = '{1'b0, 2'b00, 3'b011, 32'h1003, 32'h0,       32'h80FF_1234, 0, 4'b1000, 32'h0,       32'h0000_0080, 2'd0};
    tbl[1] = '{1'b0, 2'b00, 3'b010, 32'h2002, 32'h0,       32'h8001_0000, 3, 4'b1100, 32'h0,       32'hFFFF_8001, 2'd0};
    tbl[2] = '{1'b1, 2'b11, 3'b000, 32'h0010, 32'hDEADBEEF, 32'h0,        0, 4'b0011, 32'hBEEF_BEEF, 32'hFFFF_8001, 2'd0};
    tbl[3] = '{1'b1, 2'b00, 3'b000, 32'h0006, 32'h1234_5678, 32'h0,       0, 4'b0000, 32'h0,       32'hFFFF_8001, 2'd1};
    tbl[4] = '{1'b0, 2'b00, 3'b000, 32'h0040, 32'h0,       32'h5555_5555, 9, 4'b1111, 32'h0,       32'hFFFF_8001, 2'd2};
    tbl[5] = '{1'b1, 2'b01, 3'b000, 32'h0021, 32'h0000_00A5, 32'h0,       1, 4'b0010, 32'hA5A5_A5A5, 32'hFFFF_8001, 2'd0};
    tbl[6] = '{1'b0, 2'b00, 3'b111, 32'h0100, 32'h0,       32'h1234_5678, 1, 4'b1111, 32'h0,       32'h1234_5678, 2'd0};
    tbl[7] = '{1'b0, 2'b00, 3'b100, 32'h0032, 32'h0,       32'hBEEF_0000, 2, 4'b1100, 32'h0,       32'h0000_BEEF, 2'd0};
    tbl[8] = '{1'b0, 2'b00, 3'b001, 32'h0041, 32'h0,       32'h0000_8000, 0, 4'b0010, 32'h0,       32'hFFFF_FF80, 2'd0};
    tbl[9] = '{1'b0, 2'b00, 3'b010, 32'h0005, 32'h0,       32'h0,         0, 4'b0000, 32'h0,       32'hFFFF_FF80, 2'd1};

    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].rw, tbl[i].ws, tbl[i].rs, tbl[i].a, tbl[i].wd,
              tbl[i].rd, tbl[i].waits, tbl[i].be, tbl[i].bw, tbl[i].erd, tbl[i].err);
      cur_rd = tbl[i].erd;
    end

    // Timeout followed by a stray ack in ERR and IDLE.
    run_txn("stray", 1'b0, 2'b00, 3'b000, 32'h0080, 32'h0, 32'h0, 99, 4'hF, 32'h0, cur_rd, 2'd2);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_req", bif.bus_req, 0);
      chk("stray_stall", stall, 0);
      chk("stray_fault", fault, 0);
      chk("stray_rdata", rdata, cur_rd);
    end
    bif.bus_ack = 1'b0;

    // Asynchronous reset while a load is waiting on the bus.
    @(negedge clk);
    mem_en = 1'b1; MemRW = 1'b0; DataRSel = 3'b000; addr = 32'h0300;
    @(negedge clk);
    mem_en = 1'b0;
    chk("rbusy_req", bif.bus_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", bif.bus_req, 0);
    chk("arst_addr", bif.bus_addr, 0);
    chk("arst_be", bif.bus_be, 0);
    chk("arst_we", bif.bus_we, 0);
    chk("arst_wdata", bif.bus_wdata, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_fault", fault, 0);
    chk("arst_stall", stall, 0);
    @(negedge clk); rst_n = 1'b1;
    cur_rd = '0;
    run_txn("post_rst", 1'b0, 2'b00, 3'b000, 32'h0400, 32'h0, 32'h0BAD_F00D, 0, 4'hF, 32'h0,
            32'h0BAD_F00D, 2'd0);
    cur_rd = 32'h0BAD_F00D;

    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom_range(0, 1));
      ws = 2'($urandom_range(0, 3));
      rs = 3'($urandom_range(0, 7));
      a  = $urandom; wd = $urandom; rd = $urandom;
      w  = $urandom_range(0, TO + 1);
      model(rw, ws, rs, a, wd, rd, mbe, mbw, mld, mis);
      eerr = mis ? 2'd1 : (w >= TO) ? 2'd2 : 2'd0;
      erd  = (eerr != 2'd0 || rw) ? cur_rd : mld;
      run_txn($sformatf("rnd%0d", i), rw, ws, rs, a, wd, rd, w, mbe, mbw, erd, eerr);
      cur_rd = erd;
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
